// File: rtl/spike_aer_encoder.sv
// Serialises a parallel spike vector into AER address beats, lowest neuron index first,
// flagging the final address of each vector with aer_last.
module spike_aer_encoder #(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spike_valid,
    input  logic [N-1:0]              spike_in,
    output logic                      spike_ready,
    output logic                      aer_valid,
    output logic [$clog2(N)-1:0]      aer_addr,
    output logic                      aer_last,
    input  logic                      aer_ready,
    output logic                      busy,
    output logic [$clog2(N):0]        vec_count
);

    localparam int unsigned M  = $clog2(N);
    localparam int unsigned CW = M + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [CW-1:0]   vec_count_q, vec_count_d;
    logic [M-1:0]    aer_addr_q, aer_addr_d;
    logic            aer_last_q, aer_last_d;

    function automatic logic [M-1:0] lowest_idx(input logic [N-1:0] v);
        logic [M-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) idx = M'(i);
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Next-state logic; addr/last are precomputed from pending_d so they leave a flop.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        vec_count_d = vec_count_q;
        aer_addr_d  = '0;
        aer_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (spike_valid && (spike_in != '0)) begin
                    pending_d   = spike_in;
                    vec_count_d = popcount(spike_in);
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (aer_ready) begin
                    pending_d = pending_q & (pending_q - N'(1));
                    if (aer_last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SEND) begin
            aer_addr_d = lowest_idx(pending_d);
            aer_last_d = is_onehot(pending_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            vec_count_q <= '0;
            aer_addr_q  <= '0;
            aer_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            vec_count_q <= vec_count_d;
            aer_addr_q  <= aer_addr_d;
            aer_last_q  <= aer_last_d;
        end
    end

    assign aer_valid   = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign spike_ready = (state_q == IDLE);
    assign aer_addr    = aer_addr_q;
    assign aer_last    = aer_last_q;
    assign vec_count   = vec_count_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: vector table, hand-written corner sequences and random
// vectors, all checked against a queue-of-events reference model.
module tb_spike_aer_encoder;

    localparam int unsigned N = 8;
    localparam int unsigned M = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spike_valid;
    logic [N-1:0]  spike_in;
    logic          spike_ready;
    logic          aer_valid;
    logic [M-1:0]  aer_addr;
    logic          aer_last;
    logic          aer_ready;
    logic          busy;
    logic [M:0]    vec_count;

    int checks   = 0;
    int failures = 0;

    spike_aer_encoder #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_valid (spike_valid),
        .spike_in    (spike_in),
        .spike_ready (spike_ready),
        .aer_valid   (aer_valid),
        .aer_addr    (aer_addr),
        .aer_last    (aer_last),
        .aer_ready   (aer_ready),
        .busy        (busy),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each accepted vector becomes a list of events in ascending index order.
    typedef struct {
        int addr;
        int last;
    } ev_t;

    ev_t exp_q[$];
    int  exp_vc    = 0;
    bit  stall_q   = 0;
    int  stall_a   = 0;
    int  stall_l   = 0;

    always @(negedge clk) begin
        bit idle_now;
        int top;
        if (!rst_n) begin
            exp_q.delete();
            exp_vc  = 0;
            stall_q = 0;
            chk("rst_aer_valid", int'(aer_valid), 0);
            chk("rst_aer_addr", int'(aer_addr), 0);
            chk("rst_aer_last", int'(aer_last), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_vec_count", int'(vec_count), 0);
        end else begin
            idle_now = (exp_q.size() == 0);
            chk("mon_vec_count", int'(vec_count), exp_vc);
            chk("mon_aer_valid", int'(aer_valid), idle_now ? 0 : 1);
            chk("mon_busy", int'(busy), idle_now ? 0 : 1);
            chk("mon_spike_ready", int'(spike_ready), idle_now ? 1 : 0);
            if (idle_now) begin
                chk("mon_idle_addr", int'(aer_addr), 0);
                chk("mon_idle_last", int'(aer_last), 0);
            end else begin
                chk("mon_addr", int'(aer_addr), exp_q[0].addr);
                chk("mon_last", int'(aer_last), exp_q[0].last);
            end
            if (stall_q) begin
                chk("stall_valid_held", int'(aer_valid), 1);
                chk("stall_addr_held", int'(aer_addr), stall_a);
                chk("stall_last_held", int'(aer_last), stall_l);
            end
            stall_q = !idle_now && !aer_ready;
            stall_a = int'(aer_addr);
            stall_l = int'(aer_last);
            if (!idle_now && aer_ready) void'(exp_q.pop_front());
            if (idle_now && spike_valid && (spike_in != '0)) begin
                top = 0;
                for (int i = 0; i < int'(N); i++) if (spike_in[i]) top = i;
                for (int i = 0; i < int'(N); i++) begin
                    if (spike_in[i]) exp_q.push_back('{addr: i, last: (i == top) ? 1 : 0});
                end
                exp_vc = $countones(spike_in);
            end
        end
    end

    // mode 0: aer_ready high; 1: toggling starting high; 2: random.
    task automatic send_vec(input logic [N-1:0] v, input int mode,
                            output int beats, output int first_a, output int last_a);
        int  guard;
        bit  done;
        bit  tog;
        beats   = 0;
        first_a = -1;
        last_a  = -1;
        guard   = 0;
        while (!spike_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 0, 1);
        spike_valid = 1'b1;
        spike_in    = v;
        step();
        spike_valid = 1'b0;
        spike_in    = N'($urandom);
        if (v == '0) return;
        done  = 0;
        tog   = 1;
        guard = 0;
        while (!done && guard < 200) begin
            case (mode)
                0:       aer_ready = 1'b1;
                1:       aer_ready = tog;
                default: aer_ready = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (aer_valid && aer_ready) begin
                if (beats == 0) first_a = int'(aer_addr);
                last_a = int'(aer_addr);
                beats++;
                if (aer_last) done = 1;
            end
            step();
            guard++;
        end
        if (!done) chk("beat_timeout", 0, 1);
        aer_ready = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] vec;
        int           mode;
        int           exp_vc;
        int           exp_beats;
        int           exp_first;
        int           exp_last;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   beats, first_a, last_a;
        int   ev_v[4], ev_a[4], ev_l[4], ev_r[4];
        logic [N-1:0] rv;

        tbl[0] = '{8'h25, 0, 3, 3, 0, 5};
        tbl[1] = '{8'h00, 0, 3, 0, -1, -1};
        tbl[2] = '{8'hFF, 1, 8, 8, 0, 7};
        tbl[3] = '{8'h80, 0, 1, 1, 7, 7};
        tbl[4] = '{8'h03, 0, 2, 2, 0, 1};
        tbl[5] = '{8'h10, 2, 1, 1, 4, 4};
        tbl[6] = '{8'hAA, 1, 4, 4, 1, 7};
        tbl[7] = '{8'h5A, 2, 4, 4, 1, 6};
        tbl[8] = '{8'h00, 0, 4, 0, -1, -1};

        rst_n       = 1'b0;
        spike_valid = 1'b0;
        spike_in    = '0;
        aer_ready   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_spike_ready", int'(spike_ready), 1);
        chk("reset_aer_valid", int'(aer_valid), 0);
        chk("reset_vec_count", int'(vec_count), 0);

        foreach (tbl[k]) begin
            send_vec(tbl[k].vec, tbl[k].mode, beats, first_a, last_a);
            chk($sformatf("tbl%0d_beats", k), beats, tbl[k].exp_beats);
            chk($sformatf("tbl%0d_first", k), first_a, tbl[k].exp_first);
            chk($sformatf("tbl%0d_last", k), last_a, tbl[k].exp_last);
            chk($sformatf("tbl%0d_vec_count", k), int'(vec_count), tbl[k].exp_vc);
            chk($sformatf("tbl%0d_ready_after", k), int'(spike_ready), 1);
            chk($sformatf("tbl%0d_valid_after", k), int'(aer_valid), 0);
        end

        // Back-to-back 8'h03 then 8'h10 with spike_valid held throughout.
        ev_v = '{1, 1, 0, 1};
        ev_a = '{0, 1, 0, 4};
        ev_l = '{0, 1, 0, 1};
        ev_r = '{0, 0, 1, 0};
        aer_ready   = 1'b1;
        spike_valid = 1'b1;
        spike_in    = 8'h03;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b%0d_valid", i), int'(aer_valid), ev_v[i]);
            chk($sformatf("b2b%0d_addr", i), int'(aer_addr), ev_a[i]);
            chk($sformatf("b2b%0d_last", i), int'(aer_last), ev_l[i]);
            chk($sformatf("b2b%0d_ready", i), int'(spike_ready), ev_r[i]);
            if (i == 0) spike_in = 8'h10;
            if (i == 3) spike_valid = 1'b0;
            step();
        end
        chk("b2b_end_ready", int'(spike_ready), 1);
        chk("b2b_end_vec_count", int'(vec_count), 1);

        // Reset asserted mid-SEND of 8'hF0 after its first beat.
        spike_valid = 1'b1;
        spike_in    = 8'hF0;
        step();
        spike_valid = 1'b0;
        chk("rstmid_first_addr", int'(aer_addr), 4);
        step();
        chk("rstmid_second_addr", int'(aer_addr), 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", int'(aer_valid), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_vec_count", int'(vec_count), 0);
        aer_ready = 1'b0;
        repeat (2) step();
        rst_n     = 1'b1;
        aer_ready = 1'b1;
        repeat (3) begin
            step();
            chk("rstmid_no_residual", int'(aer_valid), 0);
        end
        aer_ready = 1'b0;
        send_vec(8'h01, 0, beats, first_a, last_a);
        chk("rstmid_next_beats", beats, 1);
        chk("rstmid_next_addr", first_a, 0);

        // Random vectors with random downstream backpressure.
        for (int n = 0; n < 40; n++) begin
            rv = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            repeat ($urandom_range(0, 2)) step();
            send_vec(rv, 2, beats, first_a, last_a);
            chk($sformatf("rnd%0d_beats", n), beats, $countones(rv));
        end

        step();
        chk("final_model_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
- Converts an N-bit parallel spike vector into a serial stream of address-event (AER) words, one neuron index per beat. It is the inverse of the team's one-hot address decoder.
- Sits between a neuron-layer spike output and the inter-layer or off-chip AER link.
- Captures a full spike vector with a valid/ready handshake, then emits the index of every set bit, LSB first.
- Marks the final address of each vector with a last flag.

Parameters:
- N, 8, number of spike inputs (neurons); must be >= 2.
- M, $clog2(N), localparam; address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- spike_valid  input  1  spike_in holds a vector to be encoded.
- spike_in  input  N  spike vector; bit i = neuron i fired.
- spike_ready  output  1  encoder can accept a vector this cycle.
- aer_valid  output  1  aer_addr holds a valid event.
- aer_addr  output  M  index of the neuron being reported.
- aer_last  output  1  current event is the final one of its vector.
- aer_ready  input  1  downstream accepts the event this cycle.
- busy  output  1  encoder is in SEND state.
- vec_count  output  M+1  number of set bits in the vector being sent.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pending=0, vec_count=0.
  - aer_valid=0, aer_last=0, aer_addr=0, busy=0, spike_ready=1 once reset releases.
  - Reset asserted mid-SEND discards remaining events with no partial completion.
- State machine: two states, IDLE and SEND.
- IDLE:
  - spike_ready=1, aer_valid=0, busy=0.
  - Accept occurs when spike_valid=1 (spike_ready is 1).
  - spike_in==0: vector consumed, no events emitted, stay IDLE, vec_count unchanged.
  - spike_in!=0: pending<=spike_in, vec_count<=popcount(spike_in), go to SEND next cycle.
- SEND:
  - spike_ready=0, busy=1, aer_valid=1.
  - aer_addr = index of lowest set bit of pending.
  - aer_last=1 iff pending has exactly one set bit.
  - Beat completes on aer_valid && aer_ready: clear that bit in pending. If aer_last was 1, go to IDLE next cycle.
  - aer_ready=0: pending, aer_addr and aer_last held stable; aer_valid never drops before its beat completes.
- Latency and throughput:
  - First event appears on the cycle after acceptance.
  - A vector with K set bits needs K SEND cycles when aer_ready is held high, plus 1 IDLE cycle before the next accept.
  - Accept-to-accept minimum is K+1 cycles.
- Outputs are derived only from state/pending registers; no combinational path from spike_in or spike_valid to any output.
- Outputs aer_addr and aer_last are don't-care-free: when aer_valid=0 they read 0.
- vec_count holds its value until the next non-zero vector is accepted.
- spike_valid held high with an unchanged vector while busy is ignored; the source must hold it until spike_ready.
- Boundary cases:
  - All ones: N events, addresses 0..N-1, last on N-1.
  - Single bit N-1: one event, aer_addr=N-1, aer_last=1.

Test Plan:
- Reset then spike_in=8'b0010_0101, aer_ready=1 -> aer_addr 0,2,5 on three consecutive cycles; aer_last only with 5; vec_count=3; spike_ready back to 1 on the following cycle.
- spike_in=8'h00 with spike_valid=1 -> accepted in 1 cycle, aer_valid stays 0, vec_count unchanged, state IDLE.
- spike_in=8'hFF, aer_ready toggling 1,0,1,0... -> addresses 0..7 each held stable while aer_ready=0; 8 beats total; aer_last on 7; vec_count=8.
- spike_in=8'b1000_0000 -> single beat, aer_addr=7, aer_last=1.
- Back-to-back vectors 8'h03 then 8'h10 with spike_valid held -> events 0,1(last), then one idle cycle, then 4(last); second vector accepted only when spike_ready=1.
- Assert rst_n low during SEND of 8'hF0 after the first beat -> aer_valid=0, busy=0 immediately; after release no residual events; next vector 8'h01 emits only addr 0.
